// File: rtl/tmr_voter_monitor_if.sv
// TMR voter bus: three redundant lanes in,
// voted word plus lane-health state out.
interface tmr_voter_monitor_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             IN_VALID;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             CLR_FAULT;
  logic             OUT_VALID;
  logic [WIDTH-1:0] OUT;
  logic             MISMATCH;
  logic             UNCORR;
  logic [CNT_W-1:0] ERR_A;
  logic [CNT_W-1:0] ERR_B;
  logic [CNT_W-1:0] ERR_C;
  logic [2:0]       FAULT;
  logic             FAIL;

  modport master (
    output IN_VALID, A, B, C, CLR_FAULT,
    input  OUT_VALID, OUT, MISMATCH, UNCORR,
    input  ERR_A, ERR_B, ERR_C, FAULT, FAIL
  );

  modport slave (
    input  IN_VALID, A, B, C, CLR_FAULT,
    output OUT_VALID, OUT, MISMATCH, UNCORR,
    output ERR_A, ERR_B, ERR_C, FAULT, FAIL
  );
endinterface

// File: rtl/tmr_voter_monitor.sv
// Registered bitwise 2-of-3 voter with per-lane
// disagreement counters and sticky fault tracking.
module tmr_voter_monitor #(
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 8,
  parameter int FAULT_THRESH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  tmr_voter_monitor_if.slave   bus
);
  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAULTED = 2'd2
  } lane_st_e;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] THR =
    CNT_W'(FAULT_THRESH);

  logic [2:0][WIDTH-1:0] lane;
  logic [WIDTH-1:0]      maj;
  logic [2:0]            dis;

  logic [WIDTH-1:0] out_q;
  logic             ovld_q;
  logic             mis_q;
  logic             unc_q;

  lane_st_e         st_q  [3];
  lane_st_e         st_d  [3];
  logic [CNT_W-1:0] run_q [3];
  logic [CNT_W-1:0] run_d [3];
  logic [CNT_W-1:0] err_q [3];
  logic [CNT_W-1:0] err_d [3];
  logic [2:0]       flt;

  assign lane = {bus.C, bus.B, bus.A};
  assign maj  = (bus.A & bus.B)
              | (bus.B & bus.C)
              | (bus.C & bus.A);

  // Full-word disagreement of each lane vs. the vote
  always_comb begin
    dis = '0;
    for (int i = 0; i < 3; i++)
      dis[i] = (lane[i] != maj);
  end

  // Voted data path; OUT holds across idle cycles
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q  <= '0;
      ovld_q <= 1'b0;
      mis_q  <= 1'b0;
      unc_q  <= 1'b0;
    end else begin
      ovld_q <= bus.IN_VALID;
      mis_q  <= bus.IN_VALID & (|dis);
      unc_q  <= bus.IN_VALID & (&dis);
      if (bus.IN_VALID)
        out_q <= maj;
    end
  end

  // Per-lane health state, run and error registers
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (RST) begin
        st_q[i]  <= HEALTHY;
        run_q[i] <= '0;
        err_q[i] <= '0;
      end else begin
        st_q[i]  <= st_d[i];
        run_q[i] <= run_d[i];
        err_q[i] <= err_d[i];
      end
    end
  end

  // Next lane state; clear beats a same-cycle sample
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      st_d[i]  = st_q[i];
      run_d[i] = run_q[i];
      err_d[i] = err_q[i];
      if (bus.CLR_FAULT) begin
        st_d[i]  = HEALTHY;
        run_d[i] = '0;
        err_d[i] = '0;
      end else if (bus.IN_VALID) begin
        if (dis[i]) begin
          if (run_q[i] != MAX)
            run_d[i] = run_q[i] + 1'b1;
          if (err_q[i] != MAX)
            err_d[i] = err_q[i] + 1'b1;
        end else begin
          run_d[i] = '0;
        end
        case (st_q[i])
          HEALTHY, SUSPECT: begin
            if (!dis[i])
              st_d[i] = HEALTHY;
            else if (run_d[i] >= THR)
              st_d[i] = FAULTED;
            else
              st_d[i] = SUSPECT;
          end
          FAULTED: st_d[i] = FAULTED;
          default: st_d[i] = HEALTHY;
        endcase
      end
    end
  end

  // Sticky fault flags and two-of-three failure
  always_comb begin
    flt = '0;
    for (int i = 0; i < 3; i++)
      flt[i] = (st_q[i] == FAULTED);
  end

  assign bus.OUT       = out_q;
  assign bus.OUT_VALID = ovld_q;
  assign bus.MISMATCH  = mis_q;
  assign bus.UNCORR    = unc_q;
  assign bus.ERR_A     = err_q[0];
  assign bus.ERR_B     = err_q[1];
  assign bus.ERR_C     = err_q[2];
  assign bus.FAULT     = flt;
  assign bus.FAIL      = (flt[0] & flt[1])
                       | (flt[1] & flt[2])
                       | (flt[0] & flt[2]);
endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Directed bench for tmr_voter_monitor with
// hand-computed expectations.
module tb_tmr_voter_monitor;
  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  tmr_voter_monitor_if #(.WIDTH(8), .CNT_W(8)) bus ();

  tmr_voter_monitor #(
    .WIDTH(8), .CNT_W(8), .FAULT_THRESH(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic drv(input logic v,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [7:0] c,
                     input logic clr);
    bus.IN_VALID  = v;
    bus.A         = a;
    bus.B         = b;
    bus.C         = c;
    bus.CLR_FAULT = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_out"},  32'(bus.OUT), 0);
    chk({tag, "_ovld"}, 32'(bus.OUT_VALID), 0);
    chk({tag, "_mis"},  32'(bus.MISMATCH), 0);
    chk({tag, "_unc"},  32'(bus.UNCORR), 0);
    chk({tag, "_erra"}, 32'(bus.ERR_A), 0);
    chk({tag, "_errb"}, 32'(bus.ERR_B), 0);
    chk({tag, "_errc"}, 32'(bus.ERR_C), 0);
    chk({tag, "_flt"},  32'(bus.FAULT), 0);
    chk({tag, "_fail"}, 32'(bus.FAIL), 0);
  endtask

  initial begin
    RST = 1'b1;
    // reset held two cycles with a valid sample
    drv(1, 8'hFF, 8'hFF, 8'hFF, 0);
    all_zero("rst1");
    drv(1, 8'hFF, 8'hFF, 8'hFF, 0);
    all_zero("rst2");
    RST = 1'b0;
    drv(1, 8'hFF, 8'hFF, 8'hFF, 0);
    chk("first_out",  32'(bus.OUT), 32'hFF);
    chk("first_ovld", 32'(bus.OUT_VALID), 1);
    chk("first_mis",  32'(bus.MISMATCH), 0);

    // single-lane error on C
    drv(1, 8'h5A, 8'h5A, 8'hA5, 0);
    chk("sl_out",  32'(bus.OUT), 32'h5A);
    chk("sl_mis",  32'(bus.MISMATCH), 1);
    chk("sl_unc",  32'(bus.UNCORR), 0);
    chk("sl_errc", 32'(bus.ERR_C), 1);
    chk("sl_erra", 32'(bus.ERR_A), 0);
    chk("sl_errb", 32'(bus.ERR_B), 0);
    drv(0, 8'h00, 8'h00, 8'h00, 0);
    chk("idle_ovld", 32'(bus.OUT_VALID), 0);
    chk("idle_mis",  32'(bus.MISMATCH), 0);
    chk("idle_hold", 32'(bus.OUT), 32'h5A);
    drv(0, 8'h00, 8'h00, 8'h00, 1);
    chk("clr0_errc", 32'(bus.ERR_C), 0);

    // uncorrectable word
    drv(1, 8'h01, 8'h02, 8'h04, 0);
    chk("uc_out",  32'(bus.OUT), 0);
    chk("uc_mis",  32'(bus.MISMATCH), 1);
    chk("uc_unc",  32'(bus.UNCORR), 1);
    chk("uc_erra", 32'(bus.ERR_A), 1);
    chk("uc_errb", 32'(bus.ERR_B), 1);
    chk("uc_errc", 32'(bus.ERR_C), 1);
    drv(0, 8'h00, 8'h00, 8'h00, 1);
    chk("clr1_erra", 32'(bus.ERR_A), 0);

    // B: 3 bad, 1 good, then 4 bad with a gap
    for (int k = 1; k <= 3; k++)
      drv(1, 8'h33, 8'hCC, 8'h33, 0);
    chk("th3_flt", 32'(bus.FAULT), 0);
    drv(1, 8'h33, 8'h33, 8'h33, 0);
    chk("thok_flt", 32'(bus.FAULT), 0);
    drv(1, 8'h33, 8'hCC, 8'h33, 0);
    drv(1, 8'h33, 8'hCC, 8'h33, 0);
    drv(0, 8'h33, 8'hCC, 8'h33, 0);
    drv(0, 8'h33, 8'hCC, 8'h33, 0);
    drv(1, 8'h33, 8'hCC, 8'h33, 0);
    chk("gap3_flt", 32'(bus.FAULT), 0);
    drv(1, 8'h33, 8'hCC, 8'h33, 0);
    chk("gap4_flt",  32'(bus.FAULT), 32'b010);
    chk("gap4_errb", 32'(bus.ERR_B), 7);
    chk("gap4_fail", 32'(bus.FAIL), 0);
    drv(1, 8'h33, 8'h33, 8'h33, 0);
    chk("sticky_b", 32'(bus.FAULT), 32'b010);
    drv(0, 8'h00, 8'h00, 8'h00, 1);
    chk("clr2_flt", 32'(bus.FAULT), 0);

    // fault A and C together
    for (int k = 1; k <= 3; k++)
      drv(1, 8'h01, 8'h00, 8'h02, 0);
    chk("ac3_fail", 32'(bus.FAIL), 0);
    drv(1, 8'h01, 8'h00, 8'h02, 0);
    chk("ac4_flt",  32'(bus.FAULT), 32'b101);
    chk("ac4_fail", 32'(bus.FAIL), 1);
    chk("ac4_erra", 32'(bus.ERR_A), 4);

    // clear with a disagreeing valid sample
    drv(1, 8'h77, 8'h77, 8'h70, 1);
    chk("cv_out",  32'(bus.OUT), 32'h77);
    chk("cv_ovld", 32'(bus.OUT_VALID), 1);
    chk("cv_mis",  32'(bus.MISMATCH), 1);
    chk("cv_flt",  32'(bus.FAULT), 0);
    chk("cv_fail", 32'(bus.FAIL), 0);
    chk("cv_erra", 32'(bus.ERR_A), 0);
    chk("cv_errb", 32'(bus.ERR_B), 0);
    chk("cv_errc", 32'(bus.ERR_C), 0);

    // C disagrees 300 times: run restarts, then saturates
    for (int k = 1; k <= 300; k++) begin
      drv(1, 8'h0F, 8'h0F, 8'hF0, 0);
      if (k == 3) begin
        chk("sat3_flt",  32'(bus.FAULT), 0);
        chk("sat3_errc", 32'(bus.ERR_C), 3);
      end
      if (k == 4)
        chk("sat4_flt", 32'(bus.FAULT), 32'b100);
      if (k == 254)
        chk("sat254", 32'(bus.ERR_C), 32'hFE);
    end
    chk("sat_errc", 32'(bus.ERR_C), 32'hFF);
    chk("sat_flt",  32'(bus.FAULT), 32'b100);
    chk("sat_erra", 32'(bus.ERR_A), 0);

    // reset mid-stream drops the sample
    RST = 1'b1;
    drv(1, 8'h3C, 8'h3C, 8'h3C, 0);
    all_zero("mrst");
    RST = 1'b0;
    drv(0, 8'h00, 8'h00, 8'h00, 0);
    chk("post_out", 32'(bus.OUT), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
